// File: rtl/ettore_ag_if.sv
// Evaluator handshake and best-so-far outputs of the ettore_ag genetic-algorithm engine.
interface ettore_ag_if #(
  parameter int ErrorWidth      = 32,
  parameter int IndividualWidth = 32
);
  logic                       fitnessStart;
  logic                       fitnessFinish;
  logic [IndividualWidth-1:0] fitnessIndividual;
  logic [ErrorWidth-1:0]      fitnessError;
  logic [IndividualWidth-1:0] bestIndividual;
  logic [ErrorWidth-1:0]      bestError;

  modport master (
    output fitnessStart, fitnessIndividual, bestIndividual, bestError,
    input  fitnessFinish, fitnessError
  );

  modport slave (
    input  fitnessStart, fitnessIndividual, bestIndividual, bestError,
    output fitnessFinish, fitnessError
  );
endinterface

// File: rtl/ettore_ag.sv
// Steady-state GA engine: tournament selection, uniform crossover, single-bit mutation.
// Optional ETTORE_AG_ELITISM_EN: a child only replaces its victim if its error is not worse.
module ettore_ag #(
  parameter int ErrorWidth             = 32,
  parameter int IndividualWidth        = 32,
  parameter int PopulationAddressWidth = 5
) (
  input  logic         clk,
  input  logic         rst,
  ettore_ag_if.master  io_fit
);
  localparam int P         = PopulationAddressWidth;
  localparam int N         = 1 << P;
  localparam int RandWidth = (IndividualWidth > 4 * P) ? IndividualWidth : 4 * P;
  localparam int RandReps  = (RandWidth + 31) / 32;
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;
  localparam logic [31:0] LfsrSeed = 32'hACE1_2468;

  typedef enum logic [2:0] {INIT_GEN, INIT_EVAL, SEL, CROSS, MUT, EVAL, REPLACE} state_t;

  state_t                     r_state, w_state_next;
  logic [31:0]                r_lfsr, w_lfsr_next;
  logic [P-1:0]               r_init_idx, w_init_idx_next;
  logic [P-1:0]               r_victim, w_victim_next;
  logic                       r_start, w_start_next;
  logic [IndividualWidth-1:0] r_indiv, w_indiv_next;
  logic [IndividualWidth-1:0] r_parent1, w_parent1_next;
  logic [IndividualWidth-1:0] r_parent2, w_parent2_next;
  logic [ErrorWidth-1:0]      r_child_err, w_child_err_next;
  logic [IndividualWidth-1:0] r_best_ind, w_best_ind_next;
  logic [ErrorWidth-1:0]      r_best_err, w_best_err_next;

  logic [IndividualWidth-1:0] r_ind_mem [N];
  logic [ErrorWidth-1:0]      r_err_mem [N];
  logic                       w_mem_we;
  logic [P-1:0]               w_mem_addr;
  logic [ErrorWidth-1:0]      w_mem_err;

  logic [RandWidth-1:0]       w_rand;
  logic [P-1:0]               w_addr [4];
  logic [31:0]                w_mut_idx;
  logic [IndividualWidth-1:0] w_mut_mask;
  logic                       w_accept;
  logic                       w_replace_ok;

  // Wide random words replicate the 32-bit LFSR and drop the excess high bits.
  assign w_rand      = RandWidth'({RandReps{r_lfsr}});
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LfsrTaps) : (r_lfsr >> 1);
  assign w_mut_idx   = r_lfsr % 32'(IndividualWidth);
  assign w_accept    = r_start & io_fit.fitnessFinish;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_addr
      assign w_addr[gi] = w_rand[gi*P +: P];
    end
    for (gi = 0; gi < IndividualWidth; gi++) begin : g_mut
      assign w_mut_mask[gi] = (w_mut_idx == 32'(gi));
    end
  endgenerate

`ifdef ETTORE_AG_ELITISM_EN
  assign w_replace_ok = (r_child_err <= r_err_mem[r_victim]);
`else
  assign w_replace_ok = 1'b1;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_start_next     = r_start;
    w_indiv_next     = r_indiv;
    w_init_idx_next  = r_init_idx;
    w_victim_next    = r_victim;
    w_parent1_next   = r_parent1;
    w_parent2_next   = r_parent2;
    w_child_err_next = r_child_err;
    w_best_ind_next  = r_best_ind;
    w_best_err_next  = r_best_err;
    w_mem_we         = 1'b0;
    w_mem_addr       = r_init_idx;
    w_mem_err        = io_fit.fitnessError;

    unique case (r_state)
      INIT_GEN: begin
        w_indiv_next = w_rand[IndividualWidth-1:0];
        w_state_next = INIT_EVAL;
      end
      INIT_EVAL: begin
        if (!r_start) begin
          w_start_next = 1'b1;
        end else if (io_fit.fitnessFinish) begin
          w_start_next = 1'b0;
          w_mem_we     = 1'b1;
          if (&r_init_idx) begin
            w_state_next = SEL;
          end else begin
            w_init_idx_next = r_init_idx + P'(1);
            w_state_next    = INIT_GEN;
          end
        end
      end
      SEL: begin
        // Ties keep the first address of each pair.
        w_parent1_next = (r_err_mem[w_addr[1]] < r_err_mem[w_addr[0]]) ?
                         r_ind_mem[w_addr[1]] : r_ind_mem[w_addr[0]];
        w_parent2_next = (r_err_mem[w_addr[3]] < r_err_mem[w_addr[2]]) ?
                         r_ind_mem[w_addr[3]] : r_ind_mem[w_addr[2]];
        w_victim_next  = w_addr[2] ^ w_addr[0];
        w_state_next   = CROSS;
      end
      CROSS: begin
        w_indiv_next = (r_parent1 & w_rand[IndividualWidth-1:0]) |
                       (r_parent2 & ~w_rand[IndividualWidth-1:0]);
        w_state_next = MUT;
      end
      MUT: begin
        w_indiv_next = r_indiv ^ w_mut_mask;
        w_state_next = EVAL;
      end
      EVAL: begin
        if (!r_start) begin
          w_start_next = 1'b1;
        end else if (io_fit.fitnessFinish) begin
          w_start_next     = 1'b0;
          w_child_err_next = io_fit.fitnessError;
          w_state_next     = REPLACE;
        end
      end
      REPLACE: begin
        w_mem_addr   = r_victim;
        w_mem_err    = r_child_err;
        w_mem_we     = w_replace_ok;
        w_state_next = SEL;
      end
      default: w_state_next = INIT_GEN;
    endcase

    if (w_accept && (io_fit.fitnessError < r_best_err)) begin
      w_best_ind_next = r_indiv;
      w_best_err_next = io_fit.fitnessError;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_GEN;
      r_lfsr      <= LfsrSeed;
      r_init_idx  <= '0;
      r_victim    <= '0;
      r_start     <= 1'b0;
      r_indiv     <= '0;
      r_parent1   <= '0;
      r_parent2   <= '0;
      r_child_err <= '0;
      r_best_ind  <= '0;
      r_best_err  <= '1;
    end else begin
      r_state     <= w_state_next;
      r_lfsr      <= w_lfsr_next;
      r_init_idx  <= w_init_idx_next;
      r_victim    <= w_victim_next;
      r_start     <= w_start_next;
      r_indiv     <= w_indiv_next;
      r_parent1   <= w_parent1_next;
      r_parent2   <= w_parent2_next;
      r_child_err <= w_child_err_next;
      r_best_ind  <= w_best_ind_next;
      r_best_err  <= w_best_err_next;
    end
  end

  // Population contents are rebuilt by INIT after every reset, so the arrays carry no reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_ind_mem[w_mem_addr] <= r_indiv;
      r_err_mem[w_mem_addr] <= w_mem_err;
    end
  end

  assign io_fit.fitnessStart      = r_start;
  assign io_fit.fitnessIndividual = r_indiv;
  assign io_fit.bestIndividual    = r_best_ind;
  assign io_fit.bestError         = r_best_err;
endmodule

// File: tb/tb_ettore_ag.sv
// Scoreboard bench for ettore_ag with a 4-entry population and a scripted evaluator.
module tb_ettore_ag;
  localparam int EW = 32;
  localparam int IW = 32;
  localparam int PW = 2;
  localparam int N  = 4;
  localparam logic [31:0] SEED   = 32'hACE1_2468;
  localparam logic [31:0] SECOND = 32'h159C_248D;
  localparam logic [31:0] XMASK  = 32'hAAAA_AAAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ettore_ag_if #(.ErrorWidth(EW), .IndividualWidth(IW)) fit ();

  ettore_ag #(
    .ErrorWidth(EW), .IndividualWidth(IW), .PopulationAddressWidth(PW)
  ) dut (
    .clk(clk), .rst(rst), .io_fit(fit)
  );

  int checks = 0;
  int errors = 0;

  // Evaluator modes: 0 hold, 1 constant error, 2 individual^0xAAAAAAAA, 3 init 7 / child all-ones.
  int          mode = 0;
  int          latency = 1;
  int          wait_cnt = 0;
  int          n_eval = 0;
  logic [31:0] const_err = 32'd5;

  logic [63:0] sb_q[$];
  logic [31:0] rise_ind[$];
  int          gaps[$];
  logic [31:0] m_best_err = '1;
  logic [31:0] m_best_ind = '0;
  logic [31:0] init_min = '1;
  logic [31:0] last_best = '1;
  logic        prev_start = 1'b0;
  logic        seen_fall = 1'b0;
  int          low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [31:0] eval_err(input logic [31:0] ind);
    case (mode)
      1:       return const_err;
      2:       return ind ^ XMASK;
      3:       return (n_eval < N) ? 32'd7 : 32'hFFFF_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  // Evaluator: raises a one-cycle finish after the configured number of cycles of fitnessStart.
  initial begin
    fit.fitnessFinish = 1'b0;
    fit.fitnessError  = '0;
    forever begin
      @(negedge clk);
      if (fit.fitnessFinish) begin
        fit.fitnessFinish = 1'b0;
      end else if (rst || !fit.fitnessStart || mode == 0) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= ((mode == 2) ? 1 + (n_eval % 3) : latency)) begin
          fit.fitnessFinish = 1'b1;
          fit.fitnessError  = eval_err(fit.fitnessIndividual);
          wait_cnt = 0;
        end
      end
    end
  end

  // Stimulus side of the scoreboard: each accepted finish pushes the best pair it should produce.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && fit.fitnessStart && fit.fitnessFinish) begin
        n_eval++;
        if (n_eval <= N && fit.fitnessError < init_min) init_min = fit.fitnessError;
        if (fit.fitnessError < m_best_err) begin
          m_best_err = fit.fitnessError;
          m_best_ind = fit.fitnessIndividual;
        end
        sb_q.push_back({m_best_ind, m_best_err});
      end
    end
  end

  // Monitor: a falling fitnessStart marks a completed evaluation; rises log request spacing.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_start && !fit.fitnessStart) begin
          if (sb_q.size() == 0) begin
            fail_now("sb_unexpected_completion");
          end else begin
            e = sb_q.pop_front();
            check("best_err", fit.bestError, e[31:0]);
            check("best_ind", fit.bestIndividual, e[63:32]);
            if (mode == 2) begin
              check("xor_invariant", fit.bestIndividual ^ XMASK, fit.bestError);
              check("best_monotonic", 32'(fit.bestError <= last_best), 32'd1);
              last_best = fit.bestError;
            end
          end
          seen_fall = 1'b1;
          low_cnt   = 1;
        end else if (!prev_start && fit.fitnessStart) begin
          rise_ind.push_back(fit.fitnessIndividual);
          if (seen_fall) gaps.push_back(low_cnt);
        end else if (!fit.fitnessStart) begin
          low_cnt++;
        end
      end
      prev_start = fit.fitnessStart;
    end
  end

  task automatic clear_model();
    sb_q.delete();
    rise_ind.delete();
    gaps.delete();
    seen_fall  = 1'b0;
    n_eval     = 0;
    m_best_err = '1;
    m_best_ind = '0;
    init_min   = '1;
    last_best  = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_model();
    rst = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    int k = 0;
    while (rise_ind.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rise_ind.size() < n) fail_now(name);
  endtask

  task automatic wait_gaps(input int n, input int budget, input string name);
    int k = 0;
    while (gaps.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (gaps.size() < n) fail_now(name);
  endtask

  task automatic wait_evals(input int n, input int budget, input string name);
    int k = 0;
    while (n_eval < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_eval < n) fail_now(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_gaps[6] = '{2, 2, 2, 4, 5, 5};
    logic [31:0] held_ind;
    logic        start_ok;
    logic        ind_ok;
    logic        got;
    int          cnt7;
    int          cntf;

    // Reset values and a stalled first request.
    mode = 0;
    do_reset();
    check("rst_start", 32'(fit.fitnessStart), 32'd0);
    check("rst_indiv", fit.fitnessIndividual, 32'd0);
    check("rst_best_err", fit.bestError, 32'hFFFF_FFFF);
    check("rst_best_ind", fit.bestIndividual, 32'd0);
    wait_rises(1, 20, "first_request");
    if (rise_ind.size() >= 1) check("first_indiv_seed", rise_ind[0], SEED);
    held_ind = fit.fitnessIndividual;
    start_ok = 1'b1;
    ind_ok   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start_ok &= fit.fitnessStart;
      ind_ok   &= (fit.fitnessIndividual == held_ind);
    end
    check("stall_start_high", 32'(start_ok), 32'd1);
    check("stall_indiv_stable", 32'(ind_ok), 32'd1);
    check("stall_best_err", fit.bestError, 32'hFFFF_FFFF);
    const_err = 32'd5;
    latency   = 1;
    mode      = 1;
    got       = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      got = fit.fitnessStart && fit.fitnessFinish;
    end
    if (!got) fail_now("stall_release");
    @(negedge clk);
    check("release_start_low", 32'(fit.fitnessStart), 32'd0);

    // One-cycle evaluator: second candidate is the seed advanced three steps.
    do_reset();
    wait_rises(2, 40, "second_request");
    if (rise_ind.size() >= 2) begin
      check("init0_indiv", rise_ind[0], SEED);
      check("init1_indiv", rise_ind[1], SECOND);
    end

    // Ten-cycle evaluator: four init requests, then generation spacing.
    latency = 10;
    do_reset();
    wait_gaps(6, 400, "gap_count");
    for (int i = 0; i < 6; i++)
      if (gaps.size() > i) check("request_gap", 32'(gaps[i]), 32'(exp_gaps[i]));

    // Reset while a request is outstanding restarts the full init.
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = fit.fitnessStart;
    end
    if (!got) fail_now("midop_request");
    rst = 1'b1;
    @(negedge clk);
    check("midop_start_low", 32'(fit.fitnessStart), 32'd0);
    clear_model();
    rst = 1'b0;
    wait_gaps(5, 400, "midop_regap");
    if (rise_ind.size() >= 1) check("midop_indiv_seed", rise_ind[0], SEED);
    for (int i = 0; i < 5; i++)
      if (gaps.size() > i) check("midop_gap", 32'(gaps[i]), 32'(exp_gaps[i]));

    // Best tracking under the xor error function.
    mode = 2;
    do_reset();
    wait_evals(2000, 30000, "xor_evals");
    repeat (2) @(negedge clk);
    check("best_below_init_min", 32'(fit.bestError < init_min), 32'd1);

    // Init errors 7, children all-ones: elitism decides whether the 7s survive.
    mode    = 3;
    latency = 1;
    do_reset();
    wait_evals(N + 20, 2000, "elite_evals");
    repeat (3) @(negedge clk);
    cnt7 = 0;
    cntf = 0;
    for (int i = 0; i < N; i++) begin
      if (dut.r_err_mem[i] == 32'd7) cnt7++;
      if (dut.r_err_mem[i] == 32'hFFFF_FFFF) cntf++;
    end
`ifdef ETTORE_AG_ELITISM_EN
    check("elite_all_seven", 32'(cnt7), 32'(N));
`else
    check("noelite_overwritten", 32'(cntf > 0), 32'd1);
    check("noelite_entry_values", 32'(cnt7 + cntf), 32'(N));
`endif
    check("elite_best_err", fit.bestError, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ettore_ag.md
# ettore_ag

Steady-state genetic-algorithm engine that evolves a population of fixed-width bit-string individuals toward minimum error. Fitness is computed outside the block: the engine presents one individual at a time on a request/finish handshake to an external evaluator and receives an unsigned error back. It sits between a problem-specific fitness evaluator and whatever consumes the best solution found so far.

## Interface
- ErrorWidth, 32, width of the error returned by the evaluator; lower is better.
- IndividualWidth, 32, bits per individual.
- PopulationAddressWidth, 5, population size N = 2^PopulationAddressWidth entries.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- fitnessStart  out  1  evaluation request, level, registered.
- fitnessFinish  in  1  evaluator done; error valid in the same cycle.
- fitnessIndividual  out  IndividualWidth  individual under evaluation; stable while fitnessStart=1.
- fitnessError  in  ErrorWidth  error of fitnessIndividual, sampled when fitnessFinish=1.
- bestIndividual  out  IndividualWidth  best individual evaluated since reset.
- bestError  out  ErrorWidth  error of bestIndividual.

## Operation
- Storage: N-entry individual array plus N-entry error array, asynchronous read, synchronous write.
- Random source: 32-bit Galois LFSR, taps 0x80200003, seed 0xACE12468 on reset, advances every cycle. Random words wider than 32 bits are formed by replicating the LFSR value and truncating to width.
- FSM states: INIT_GEN, INIT_EVAL, SEL, CROSS, MUT, EVAL, REPLACE.
- INIT_GEN: candidate = random word; go to INIT_EVAL.
- INIT_EVAL: handshake; on finish, write candidate and error to address initIdx.
  - If initIdx = N-1, go to SEL; else initIdx+1 and back to INIT_GEN.
- SEL: two binary tournaments.
  - Addresses a, b from LFSR bits [P-1:0] and [2P-1:P]; c, d from [3P-1:2P] and [4P-1:3P], with P = PopulationAddressWidth.
  - Parent1 is the lower-error entry of a/b; parent2 is the lower-error entry of c/d. Ties go to the first address.
  - Victim address v = c XOR a.
- CROSS: uniform crossover. With m a random mask, child = (parent1 & m) | (parent2 & ~m).
- MUT: flip exactly one bit of the child, at index (LFSR mod IndividualWidth).
- EVAL: handshake on the child.
- REPLACE: write child and its error to address v; go to SEL. Runs forever until reset.
- Best tracking: on every accepted fitnessFinish, if error < bestError, update bestIndividual/bestError. A tie keeps the old best.
- Errors are compared as unsigned; no arithmetic on errors.

## Timing
- Reset, in the cycle after an edge with rst=1:
  - fitnessStart=0, fitnessIndividual=0.
  - bestIndividual=0, bestError all-ones.
  - state=INIT_GEN, initIdx=0, LFSR=seed.
- Reset mid-evaluation aborts the request. Population contents are don't-care after reset; they are overwritten during INIT.
- Handshake:
  - fitnessStart rises one cycle after entering INIT_EVAL/EVAL.
  - It stays high until fitnessFinish is sampled high.
  - It is cleared on that same edge and held low for at least one cycle before the next request.
- fitnessFinish is ignored while fitnessStart=0. A finish level held over multiple cycles counts once.
- The evaluator may respond in 1 cycle or take arbitrarily long; no timeout.
- Non-handshake states take one cycle each, so a generation costs 5 cycles plus evaluator latency.

## Configuration
- ETTORE_AG_ELITISM_EN defined: REPLACE writes only if childError <= error[v]; otherwise the child is discarded. The population's best entry can therefore never be lost.
- Not defined: REPLACE always overwrites entry v.

## Test plan
- Reset: assert rst 2 cycles, then hold fitnessFinish=0. Required: fitnessStart=0 in the cycle after reset; bestError=0xFFFFFFFF and bestIndividual=0 until the first finish.
- Init count: PopulationAddressWidth=2, evaluator returns 5 after 10 cycles. Required: exactly 4 requests before the first SEL; the first fitnessIndividual is derived from seed 0xACE12468.
- Stall: hold fitnessFinish low 100 cycles. Required: fitnessStart stays 1 and fitnessIndividual is unchanged throughout. Then a 1-cycle finish: required fitnessStart=0 on the next cycle.
- Best tracking: error = individual ^ 0xAAAAAAAA for 2000 evaluations. Required: bestError never increases, bestIndividual ^ 0xAAAAAAAA == bestError at all times, and the final bestError is below the minimum found during INIT.
- Elitism: with ETTORE_AG_ELITISM_EN, init errors = 7 and all child errors = 0xFFFFFFFF. Required: the error array stays all 7. Without the macro: entries become 0xFFFFFFFF.
- Mid-op reset: pulse rst while fitnessStart=1. Required: fitnessStart=0 the next cycle, and the block re-runs the full N-entry init.
